// File: rtl/udp_tx_scheduler_pkg.sv
// Shared Ethernet types for the UDP transmit path: address block, command frame
// layout and scheduler state encoding.
package udp_tx_scheduler_pkg;

  localparam int UDP_CMD_BYTES = 27;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [47:0] src_mac;
    logic [15:0] src_port;
    logic [31:0] dest_ip;
    logic [47:0] dest_mac;
    logic [15:0] dest_port;
  } IPInfo;

  // Field order matches the UART byte order, first byte in the top bits.
  typedef struct packed {
    IPInfo      ip;
    logic [7:0] seed;
    logic [7:0] generator;
    logic [7:0] count;
  } udp_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ARM,
    ST_ACK,
    ST_DONE,
    ST_GAP
  } sched_state_t;

endpackage

// File: rtl/udp_cmd_collector.sv
// Assembles 27-byte command frames from the UART byte stream into a one-deep
// pending slot; partial frames time out and overwritten frames are reported.
module udp_cmd_collector
  import udp_tx_scheduler_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic [7:0] i_rx_data,
  input  logic     i_rx_valid,
  input  logic     i_clear,
  output logic     o_pending,
  output udp_cmd_t o_shadow,
  output logic     o_dropped
);

  localparam int             TW      = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(BYTE_TIMEOUT);
  localparam int             SW      = (UDP_CMD_BYTES - 1) * 8;

  logic [4:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic [SW-1:0] r_shift;
  udp_cmd_t      r_shadow;
  logic          r_pending;
  logic          r_dropped;
  logic          w_expire;
  logic          w_last;

  assign w_expire = (r_idx != 5'd0) && (r_tmo == TMO_MAX);
  // A byte landing on the expiry cycle starts a new frame, so it never completes one.
  assign w_last   = i_rx_valid && !w_expire && (r_idx == 5'(UDP_CMD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_tmo     <= '0;
      r_pending <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_expire;
      if (i_rx_valid || w_expire || (r_idx == 5'd0)) r_tmo <= '0;
      else                                           r_tmo <= r_tmo + 1'b1;

      if (i_rx_valid) begin
        if (w_expire)    r_idx <= 5'd1;
        else if (w_last) r_idx <= 5'd0;
        else             r_idx <= r_idx + 5'd1;
      end else if (w_expire) begin
        r_idx <= 5'd0;
      end

      if (w_last) begin
        r_pending <= 1'b1;
        if (r_pending && !i_clear) r_dropped <= 1'b1;
      end else if (i_clear) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rx_valid) r_shift <= {r_shift[SW-9:0], i_rx_data};
    if (w_last)     r_shadow <= {r_shift, i_rx_data};
  end

  assign o_pending = r_pending;
  assign o_shadow  = r_shadow;
  assign o_dropped = r_dropped;

endmodule

// File: rtl/udp_tx_scheduler.sv
// Commits collected command frames and drives the UDP transmitter's send/ready
// handshake for a burst of packets separated by a programmable idle gap.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES   = 1000,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic       send,
  output IPInfo      ip_info,
  output logic [7:0] seed,
  output logic [7:0] generator,
  output logic       busy,
  output logic       frame_dropped
);

  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  sched_state_t  r_state;
  IPInfo         r_ip;
  logic [7:0]    r_seed;
  logic [7:0]    r_gen;
  logic [7:0]    r_count;
  logic [7:0]    r_idx;
  logic [GW-1:0] r_gap;
  logic          r_send;
  logic          r_busy;
  logic          w_pending;
  logic          w_commit;
  udp_cmd_t      w_shadow;

  assign w_commit = (r_state == ST_IDLE) && w_pending;

  udp_cmd_collector #(
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) u_collector (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_clear    (w_commit),
    .o_pending  (w_pending),
    .o_shadow   (w_shadow),
    .o_dropped  (frame_dropped)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ip    <= '0;
      r_seed  <= '0;
      r_gen   <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_send  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // busy drops one cycle after re-entering IDLE unless a new burst starts.
          r_busy <= w_pending;
          if (w_pending) begin
            r_ip    <= w_shadow.ip;
            r_seed  <= w_shadow.seed;
            r_gen   <= w_shadow.generator;
            r_count <= w_shadow.count;
            r_idx   <= 8'd0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: r_state <= (r_count == 8'd0) ? ST_IDLE : ST_ARM;
        ST_ARM: begin
          if (tx_ready) begin
            r_send  <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: if (!tx_ready) r_state <= ST_DONE;
        ST_DONE: begin
          if (tx_ready) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx + 8'd1 == r_count) begin
              r_state <= ST_IDLE;
            end else begin
              r_seed  <= r_seed + 8'd1;
              r_gap   <= GAP_LOAD;
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == '0) r_state <= ST_ARM;
          else             r_gap   <= r_gap - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign send      = r_send;
  assign ip_info   = r_ip;
  assign seed      = r_seed;
  assign generator = r_gen;
  assign busy      = r_busy;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler with a transmitter model that holds
// tx_ready low for a fixed number of cycles after each send.
module tb_udp_tx_scheduler;
  import udp_tx_scheduler_pkg::*;

  localparam int GAP     = 20;
  localparam int TMO     = 40;
  localparam int TXB     = 50;
  localparam int SPACING = TXB + GAP + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready = 1'b1;
  logic       send;
  IPInfo      ip_info;
  logic [7:0] seed;
  logic [7:0] generator;
  logic       busy;
  logic       frame_dropped;

  int errors = 0;
  int checks = 0;
  int cyc = 0, nsend = 0, ndrop = 0, nbusy = 0, busy_fall = 0, viol = 0;
  int send_cyc [16];
  logic [7:0] send_seed [16];
  logic prev_send = 1'b0, prev_busy = 1'b0;
  int tx_cnt = 0;
  logic tx_arm = 1'b0;

  udp_tx_scheduler #(
    .GAP_CYCLES   (GAP),
    .BYTE_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_ready      (tx_ready),
    .send          (send),
    .ip_info       (ip_info),
    .seed          (seed),
    .generator     (generator),
    .busy          (busy),
    .frame_dropped (frame_dropped)
  );

  always #5 clk = ~clk;

  // Output monitor plus transmitter: ready falls the cycle after send is
  // registered and stays low for TXB cycles.
  always @(negedge clk) begin
    cyc++;
    if (send === 1'b1) begin
      if (nsend < 16) begin
        send_cyc[nsend]  = cyc;
        send_seed[nsend] = seed;
      end
      nsend++;
      if (prev_send || !tx_ready) viol++;
    end
    if (frame_dropped === 1'b1) ndrop++;
    if (busy === 1'b1) nbusy++;
    if (prev_busy && busy === 1'b0) busy_fall = cyc;
    prev_send = (send === 1'b1);
    prev_busy = (busy === 1'b1);
    if (tx_arm) begin
      tx_arm   = 1'b0;
      tx_ready = 1'b0;
      tx_cnt   = TXB;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_ready = 1'b1;
    end
    if (send === 1'b1) tx_arm = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nsend = 0;
    ndrop = 0;
    nbusy = 0;
  endtask

  function automatic udp_cmd_t mk(input logic [31:0] sip, input logic [7:0] sd,
                                  input logic [7:0] gen, input logic [7:0] cnt);
    udp_cmd_t f;
    f.ip.src_ip    = sip;
    f.ip.src_mac   = {16'h0200, sip};
    f.ip.src_port  = sip[15:0] ^ 16'h1234;
    f.ip.dest_ip   = ~sip;
    f.ip.dest_mac  = {16'h0A0B, ~sip};
    f.ip.dest_port = sip[31:16] + 16'h0101;
    f.seed         = sd;
    f.generator    = gen;
    f.count        = cnt;
    return f;
  endfunction

  task automatic send_frame(input udp_cmd_t f, input int nbytes);
    logic [UDP_CMD_BYTES*8-1:0] v;
    v = f;
    for (int i = 0; i < nbytes; i++) begin
      rx_valid = 1'b1;
      rx_data  = v[(UDP_CMD_BYTES-1-i)*8 +: 8];
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    udp_cmd_t f1, f2, fj, f3, f4, f5, f6, f7, f8, f9;
    int n;
    f1 = mk(32'hC0A8_0001, 8'h10, 8'h02, 8'd3);
    f2 = mk(32'hC0A8_0002, 8'h20, 8'h05, 8'd0);
    fj = mk(32'hDEAD_BEEF, 8'hAA, 8'hBB, 8'd9);
    f3 = mk(32'h0A00_0003, 8'h33, 8'h44, 8'd1);
    f4 = mk(32'h0A00_0004, 8'h50, 8'h01, 8'd5);
    f5 = mk(32'h0A00_0005, 8'h60, 8'h02, 8'd2);
    f6 = mk(32'h0A00_0006, 8'h70, 8'h03, 8'd2);
    f7 = mk(32'h0A00_0007, 8'hFE, 8'h07, 8'd3);
    f8 = mk(32'h0A00_0008, 8'h80, 8'h08, 8'd4);
    f9 = mk(32'h0A00_0009, 8'h90, 8'h09, 8'd1);

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    chk("rst_send", send, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", frame_dropped, 1'b0);
    chk("rst_ip", ip_info, '0);
    chk("rst_seed", seed, 8'h00);
    chk("rst_gen", generator, 8'h00);
    reset = 1'b0;
    tick();

    // Single frame, three packets, exact commit/send latency and spacing.
    clr();
    send_frame(f1, UDP_CMD_BYTES);
    tick();
    chk("f1_busy_c2", busy, 1'b1);
    chk("f1_ip_c2", ip_info, f1.ip);
    tick();
    chk("f1_send_c3", send, 1'b0);
    tick();
    chk("f1_send_c4", send, 1'b1);
    chk("f1_seed_c4", seed, 8'h10);
    chk("f1_gen", generator, 8'h02);
    wait_idle("f1", 1000);
    chk("f1_nsend", nsend, 3);
    chk("f1_seed1", send_seed[1], 8'h11);
    chk("f1_seed2", send_seed[2], 8'h12);
    chk("f1_space01", send_cyc[1] - send_cyc[0], SPACING);
    chk("f1_space12", send_cyc[2] - send_cyc[1], SPACING);
    chk("f1_busy_fall", busy_fall - send_cyc[2], TXB + 3);

    // count=0: no packets, busy for two cycles, addresses still committed.
    clr();
    send_frame(f2, UDP_CMD_BYTES);
    repeat (8) tick();
    chk("f2_nsend", nsend, 0);
    chk("f2_nbusy", nbusy, 2);
    chk("f2_ip", ip_info, f2.ip);
    chk("f2_gen", generator, 8'h05);

    // Partial frame times out, then a clean frame is used on its own.
    clr();
    send_frame(fj, 10);
    repeat (TMO) tick();
    chk("tmo_early", ndrop, 0);
    tick();
    chk("tmo_drop", ndrop, 1);
    send_frame(f3, UDP_CMD_BYTES);
    repeat (3) tick();
    wait_idle("f3", 1000);
    chk("f3_nsend", nsend, 1);
    chk("f3_seed", send_seed[0], 8'h33);
    chk("f3_ip", ip_info, f3.ip);
    chk("f3_gen", generator, 8'h44);
    chk("f3_ndrop", ndrop, 1);

    // Two frames during a 5-packet burst: newest wins after the burst.
    clr();
    send_frame(f4, UDP_CMD_BYTES);
    repeat (3) tick();
    send_frame(f5, UDP_CMD_BYTES);
    send_frame(f6, UDP_CMD_BYTES);
    tick();
    chk("f4_ip_hold", ip_info, f4.ip);
    chk("f4_gen_hold", generator, 8'h01);
    chk("f4_ndrop", ndrop, 1);
    wait_idle("f4f6", 2000);
    chk("f4f6_nsend", nsend, 7);
    chk("f4_seed0", send_seed[0], 8'h50);
    chk("f4_seed4", send_seed[4], 8'h54);
    chk("f6_seed0", send_seed[5], 8'h70);
    chk("f6_seed1", send_seed[6], 8'h71);
    chk("f6_ip", ip_info, f6.ip);
    chk("f6_ndrop", ndrop, 1);

    // Seed wraps modulo 256.
    clr();
    send_frame(f7, UDP_CMD_BYTES);
    repeat (3) tick();
    wait_idle("f7", 1000);
    chk("f7_nsend", nsend, 3);
    chk("f7_seed0", send_seed[0], 8'hFE);
    chk("f7_seed1", send_seed[1], 8'hFF);
    chk("f7_seed2", send_seed[2], 8'h00);

    // Reset in the gap after packet 2 of 4 aborts the burst.
    clr();
    send_frame(f8, UDP_CMD_BYTES);
    n = 0;
    while (nsend < 2 && n < 500) begin
      tick();
      n++;
    end
    chk("f8_reach2", nsend, 2);
    repeat (60) tick();
    chk("f8_busy_gap", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("mrst_send", send, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ip", ip_info, '0);
    chk("mrst_seed", seed, 8'h00);
    chk("mrst_gen", generator, 8'h00);
    reset = 1'b0;
    repeat (300) tick();
    chk("mrst_nsend", nsend, 2);
    chk("mrst_idle", busy, 1'b0);
    clr();
    send_frame(f9, UDP_CMD_BYTES);
    repeat (3) tick();
    wait_idle("f9", 1000);
    chk("f9_nsend", nsend, 1);
    chk("f9_seed", send_seed[0], 8'h90);
    chk("f9_ip", ip_info, f9.ip);
    chk("handshake_viol", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Sequences the Ethernet UDP transmitter from a byte-serial command stream delivered by the UART receiver. It assembles a 27-byte command frame, commits it, then issues a burst of N packet sends, handshaking with the transmitter's `ready`/`send` pair and inserting a programmable gap between packets. It sits between `uart_receive` and `ethernet_udp_transmit` in `main`, replacing the ad-hoc parameter shift logic there.

## Interface
- `GAP_CYCLES`, 1000: idle `clk` cycles between one packet completing and the next `send`.
- `BYTE_TIMEOUT`, 100000: `clk` cycles without `rx_valid` mid-frame before the partial frame is discarded.
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: **one clock; reset is synchronous and active-high**.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid.
- `tx_ready` in 1: transmitter idle and able to accept `send`.
- `send` out 1: one-cycle pulse that starts a packet.
- `ip_info` out `IPInfo`: addresses and ports of the active frame.
- `seed` out 8: payload seed for the current packet, equal to the frame seed plus the packet index, mod 256.
- `generator` out 8: payload generator of the active frame.
- `busy` out 1: a burst is in progress.
- `frame_dropped` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Frame byte order, MSB first within each field: src_ip(4), src_mac(6), src_port(2), dest_ip(4), dest_mac(6), dest_port(2), seed(1), generator(1), count(1). Total 27 bytes.
- Collector:
  - Always running, independent of the FSM.
  - A 5-bit byte index shifts bytes into a shadow frame register.
  - When index 26 is accepted, the collector raises `pending` and the index returns to 0.
- Timeout: if the index is nonzero and `BYTE_TIMEOUT` cycles pass with no `rx_valid`, the index returns to 0 and `frame_dropped` pulses.
- Second frame while pending: if a complete frame arrives while `pending` is already set, the newer frame overwrites the shadow register and `frame_dropped` pulses. The pending frame is held one deep, and the newest frame wins.
- FSM states:
  - IDLE: if `pending`, copy shadow to active, clear `pending`, set packet index to 0, go to CHECK.
  - CHECK: if count is 0, return to IDLE. Otherwise go to ARM.
  - ARM: wait for `tx_ready`=1. Then pulse `send` and go to ACK.
  - ACK: wait for `tx_ready`=0, meaning the transmitter accepted the packet. Then go to DONE.
  - DONE: wait for `tx_ready`=1. Then increment the packet index. If the index equals count, go to IDLE. Otherwise load the gap counter and go to GAP.
  - GAP: count down `GAP_CYCLES`, then go to ARM.
- `busy` is 1 in every state except IDLE.
- Commit timing: a frame completed during a burst is committed only after that burst returns to IDLE. Active outputs never change mid-burst.
- Arithmetic: the packet index is 8 bits. `seed` output = active seed + index, wrapping mod 256.

## Timing
- Reset values:
  - `send`=0, `busy`=0, `frame_dropped`=0.
  - `ip_info`, `seed` and `generator` are all-zero.
  - State is IDLE, `pending`=0, byte index 0.
- Reset mid-burst or mid-frame aborts immediately. No further `send` is issued.
- All outputs are registered.
- From the last byte's `rx_valid` (cycle 0) with FSM idle and `tx_ready`=1:
  - cycle 1: `pending`=1.
  - cycle 2: commit; `ip_info` valid and `busy`=1.
  - cycle 3: CHECK.
  - cycle 4: `send` pulses.
- Packet-to-packet timing: `send` to next `send` = transmitter busy time + `GAP_CYCLES` + 3 cycles.
- `send` is never asserted on two consecutive cycles. It is never asserted while `tx_ready`=0.
- Simultaneous events:
  - `rx_valid` on the same cycle the timeout expires: the byte is accepted as byte 0 of a new frame.
  - Frame completion on the same cycle as commit in IDLE: the commit takes the old shadow, and the new frame becomes pending.

## Structure
- Move `IPInfo` and a new `udp_cmd_t` packed struct into the shared Ethernet package. `udp_cmd_t` holds all 27 bytes.
- Also add `UDP_CMD_BYTES`=27 to the shared Ethernet package.
- One sub-module, `udp_cmd_collector`: byte index, timeout counter, shadow register, `pending`/`frame_dropped`. The FSM stays in `udp_tx_scheduler`.

## Test plan
- Single frame, count=3, seed=0x10, generator=0x02, `tx_ready` model busy for 50 cycles: exactly 3 `send` pulses with `seed` 0x10, 0x11, 0x12. Spacing between pulses is 50+`GAP_CYCLES`+3. `busy` falls after the third packet completes.
- count=0 frame: no `send`, `busy` high for exactly 2 cycles, `ip_info` updated.
- 10 bytes, then silence for `BYTE_TIMEOUT`+1 cycles, then a full frame: one `frame_dropped` pulse, then correct fields from the second frame only.
- Two full frames sent during a 5-packet burst: burst completes unchanged, one `frame_dropped`, then the second frame's burst runs.
- Seed wrap with seed=0xFE, count=3: `seed` goes 0xFE, 0xFF, 0x00.
- `reset` asserted in GAP of packet 2 of 4: all outputs return to zero next cycle, no further `send`, and a new frame afterwards works normally.
